// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU result display: active-high 7-segment glyphs,
// the latched result record and the ALU op codes used by neighbouring blocks.
package alu_disp_pkg;

   // Segment order is {g,f,e,d,c,b,a}, 1 = segment lit
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_R     = 7'b1010000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      SUM = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } alu_op_e;

   typedef struct packed {
      logic [3:0] dec;
      logic [3:0] unis;
      logic       zero;
      logic       error;
   } alu_result_t;

   function automatic logic [6:0] digit_glyph(input logic [3:0] digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// ALU result load channel: valid/ready handshake carrying the two BCD digits
// and the zero/error flags.
interface alu_result_display_if;
   logic       ld_valid;
   logic       ld_ready;
   logic [3:0] dec_bin;
   logic [3:0] unis_bin;
   logic       zero;
   logic       error;

   modport master (
      output ld_valid, dec_bin, unis_bin, zero, error,
      input  ld_ready
   );

   modport slave (
      input  ld_valid, dec_bin, unis_bin, zero, error,
      output ld_ready
   );
endinterface

// File: rtl/alu_result_display_seg7_decode.sv
// Combinational glyph selection for one digit slot, active-high segments.
module seg7_decode
   import alu_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       is_tens,
   input  logic       err,
   output logic [6:0] seg
);

   // Error text overrides digits; a zero tens digit is suppressed
   always_comb begin
      seg = SEG_BLANK;
      if (err) begin
         seg = is_tens ? SEG_E : SEG_R;
      end else if (is_tens && (digit == 4'd0)) begin
         seg = SEG_BLANK;
      end else begin
         seg = digit_glyph(digit);
      end
   end

endmodule

// File: rtl/alu_result_display.sv
// Double-buffered 2-digit multiplexed 7-segment driver for ALU results with
// zero/error LEDs; new results are swapped in only at frame boundaries.
module alu_result_display
   import alu_disp_pkg::*;
#(
   parameter int REFRESH_DIV    = 1024,
   parameter int BLANK_CYC      = 4,
   parameter int BLINK_DIV      = 64,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   alu_result_display_if.slave ld,
   output logic [6:0]          seg,
   output logic [1:0]          an,
   output logic                zero_led,
   output logic                err_led
);

   localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

   logic [CNT_W-1:0]   cnt_r;
   logic               dsel_r;
   logic [BLINK_W-1:0] blink_cnt_r;
   logic               blink_r;
   alu_result_t        pend_r;
   alu_result_t        disp_r;
   logic               pend_valid_r;
   logic               disp_valid_r;

   logic               slot_end_s;
   logic               frame_end_s;
   logic               accept_s;
   logic               an_on_s;
   logic [3:0]         digit_s;
   logic [6:0]         glyph_s;
   logic [6:0]         seg_s;
   logic [1:0]         an_s;

   assign ld.ld_ready = ~pend_valid_r;
   assign slot_end_s  = (cnt_r == CNT_W'(REFRESH_DIV - 1));
   assign frame_end_s = slot_end_s & dsel_r;
   assign accept_s    = ld.ld_valid & ~pend_valid_r;
   assign digit_s     = dsel_r ? disp_r.dec : disp_r.unis;

   seg7_decode u_decode (
      .digit   (digit_s),
      .is_tens (dsel_r),
      .err     (disp_r.error),
      .seg     (glyph_s)
   );

   // Slot counter and digit select
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         dsel_r <= 1'b0;
      end else if (slot_end_s) begin
         cnt_r  <= {CNT_W{1'b0}};
         dsel_r <= ~dsel_r;
      end else begin
         cnt_r  <= cnt_r + 1'b1;
      end
   end

   // Blink phase, advanced once per frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_r <= {BLINK_W{1'b0}};
         blink_r     <= 1'b0;
      end else if (frame_end_s) begin
         if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            blink_r     <= ~blink_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
         end
      end
   end

   // Pending/display buffers; capture and swap are exclusive since ready = ~pend_valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r       <= {4'd0, 4'd0, 1'b0, 1'b0};
         disp_r       <= {4'd0, 4'd0, 1'b0, 1'b0};
         pend_valid_r <= 1'b0;
         disp_valid_r <= 1'b0;
      end else if (frame_end_s && pend_valid_r) begin
         disp_r       <= pend_r;
         disp_valid_r <= 1'b1;
         pend_valid_r <= 1'b0;
      end else if (accept_s) begin
         pend_r       <= {ld.dec_bin, ld.unis_bin, ld.zero, ld.error};
         pend_valid_r <= 1'b1;
      end
   end

   // Digit enable gating: blanking window, error blink, suppressed tens
   always_comb begin
      an_on_s = 1'b0;
      seg_s   = SEG_BLANK;
      an_s    = 2'b00;
      if (disp_valid_r && (cnt_r >= CNT_W'(BLANK_CYC)) &&
          !(disp_r.error && blink_r) && (glyph_s != SEG_BLANK)) begin
         an_on_s = 1'b1;
      end else begin
         an_on_s = 1'b0;
      end
      if (an_on_s) begin
         seg_s = glyph_s;
         an_s  = dsel_r ? 2'b10 : 2'b01;
      end else begin
         seg_s = SEG_BLANK;
         an_s  = 2'b00;
      end
   end

   // Output registers, polarity applied here only
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg      <= SEG_OFF;
         an       <= AN_OFF;
         zero_led <= 1'b0;
         err_led  <= 1'b0;
      end else begin
         seg      <= SEG_ACTIVE_LOW ? ~seg_s : seg_s;
         an       <= SEG_ACTIVE_LOW ? ~an_s : an_s;
         zero_led <= disp_r.zero;
         err_led  <= disp_r.error;
      end
   end

endmodule
